audio_session_ctrl: RTL and testbench

- Top-level sequencer for the audio recorder/player; sits between the debounced key pulses and the codec-init, recorder, DSP/player and SRAM datapath.
- Runs the one-shot codec initialisation, then arbitrates record/play/pause/stop sessions.
- Owns the SRAM port select, latches the end-of-recording address, and keeps elapsed-seconds counters for the seven-segment display.

---
 rtl/audio_session_ctrl_pkg.sv | 16 +
 rtl/audio_session_ctrl_if.sv | 42 ++++
 rtl/audio_session_ctrl_sec_timer.sv | 33 +++
 rtl/audio_session_ctrl.sv | 167 ++++++++++++++++
 tb/tb_audio_session_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/audio_session_ctrl_pkg.sv
// Shared types and default widths for the audio session controller slice.
package audio_ctrl_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_TIME_W = 6;

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_IDLE       = 3'd1,
    S_REC        = 3'd2,
    S_REC_PAUSE  = 3'd3,
    S_PLAY       = 3'd4,
    S_PLAY_PAUSE = 3'd5
  } state_t;

endpackage

// File: rtl/audio_session_ctrl_if.sv
// Key inputs, datapath status and command/status outputs of the session controller.
interface audio_session_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int TIME_W = 6
);
  logic              i_key_rec;
  logic              i_key_play;
  logic              i_key_stop;
  logic              i_init_done;
  logic              i_sample_tick;
  logic [ADDR_W-1:0] i_rec_addr;
  logic [ADDR_W-1:0] i_dsp_addr;
  logic              i_dsp_done;
  logic              o_init_start;
  logic              o_rec_start;
  logic              o_rec_pause;
  logic              o_rec_stop;
  logic              o_dsp_start;
  logic              o_dsp_pause;
  logic              o_dsp_stop;
  logic              o_sram_owner;
  logic [ADDR_W-1:0] o_end_addr;
  logic [2:0]        o_state;
  logic [TIME_W-1:0] o_rec_time;
  logic [TIME_W-1:0] o_play_time;

  modport slave (
    input  i_key_rec, i_key_play, i_key_stop, i_init_done, i_sample_tick,
           i_rec_addr, i_dsp_addr, i_dsp_done,
    output o_init_start, o_rec_start, o_rec_pause, o_rec_stop,
           o_dsp_start, o_dsp_pause, o_dsp_stop, o_sram_owner,
           o_end_addr, o_state, o_rec_time, o_play_time
  );

  modport master (
    output i_key_rec, i_key_play, i_key_stop, i_init_done, i_sample_tick,
           i_rec_addr, i_dsp_addr, i_dsp_done,
    input  o_init_start, o_rec_start, o_rec_pause, o_rec_stop,
           o_dsp_start, o_dsp_pause, o_dsp_stop, o_sram_owner,
           o_end_addr, o_state, o_rec_time, o_play_time
  );
endinterface

// File: rtl/audio_session_ctrl_sec_timer.sv
// Elapsed-seconds timer: sub-second sample counter feeding a saturating seconds count.
module sec_timer #(
  parameter int SAMPLES_PER_SEC = 32000,
  parameter int TIME_W          = 6
) (
  input  logic              clk_sys,
  input  logic              rst_b,
  input  logic              en,
  input  logic              clr,
  input  logic              tick,
  output logic [TIME_W-1:0] secs
);

  localparam int SUB_W = (SAMPLES_PER_SEC > 1) ? $clog2(SAMPLES_PER_SEC) : 1;

  logic [SUB_W-1:0] sub_q;

  // Count samples while enabled; a full second rolls the sub-counter and bumps secs.
  always_ff @(posedge clk_sys) begin
    if (!rst_b || clr) begin
      sub_q <= '0;
      secs  <= '0;
    end else if (en && tick) begin
      if (sub_q == SUB_W'(SAMPLES_PER_SEC - 1)) begin
        sub_q <= '0;
        if (secs != '1) secs <= secs + 1'b1;
      end else begin
        sub_q <= sub_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_session_ctrl.sv
// Recorder/player session sequencer: codec init, session FSM, SRAM owner, timers.
//
// state        | meaning
// S_INIT       | waiting for codec init to finish, keys ignored
// S_IDLE       | no session; rec starts recording, play starts playback
// S_REC        | recording; ends on stop or when SRAM is full
// S_REC_PAUSE  | recording paused, counters held
// S_PLAY       | playback; ends on stop, player done or end address reached
// S_PLAY_PAUSE | playback paused, counters held
module audio_session_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int                ADDR_W          = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR        = ADDR_W'(20'hFFFFF),
  parameter int                SAMPLES_PER_SEC = 32000,
  parameter int                TIME_W          = DEF_TIME_W
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  audio_session_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic              init_pend_q;
  logic              init_start_q;
  logic              rec_start_q, rec_pause_q, rec_stop_q;
  logic              dsp_start_q, dsp_pause_q, dsp_stop_q;
  logic              rec_start_d, rec_pause_d, rec_stop_d;
  logic              dsp_start_d, dsp_pause_d, dsp_stop_d;
  logic              owner_q;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  logic              rec_clr, play_clr;
  logic [TIME_W-1:0] rec_time, play_time;

  // Next state, command pulses and end-address latch; stop outranks rec outranks play.
  always_comb begin
    state_d     = state_q;
    end_addr_d  = end_addr_q;
    rec_start_d = 1'b0;
    rec_pause_d = 1'b0;
    rec_stop_d  = 1'b0;
    dsp_start_d = 1'b0;
    dsp_pause_d = 1'b0;
    dsp_stop_d  = 1'b0;
    rec_clr     = 1'b0;
    play_clr    = 1'b0;
    case (state_q)
      S_INIT: begin
        if (bus.i_init_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.i_key_stop) begin
          state_d = S_IDLE;
        end else if (bus.i_key_rec) begin
          state_d     = S_REC;
          rec_start_d = 1'b1;
          rec_clr     = 1'b1;
        end else if (bus.i_key_play && (end_addr_q != '0)) begin
          state_d     = S_PLAY;
          dsp_start_d = 1'b1;
          play_clr    = 1'b1;
        end
      end
      S_REC: begin
        if (bus.i_key_stop || (bus.i_rec_addr == MAX_ADDR)) begin
          state_d    = S_IDLE;
          rec_stop_d = 1'b1;
          end_addr_d = bus.i_rec_addr;
        end else if (bus.i_key_rec) begin
          state_d     = S_REC_PAUSE;
          rec_pause_d = 1'b1;
        end
      end
      S_REC_PAUSE: begin
        if (bus.i_key_stop) begin
          state_d    = S_IDLE;
          rec_stop_d = 1'b1;
          end_addr_d = bus.i_rec_addr;
        end else if (bus.i_key_rec) begin
          state_d     = S_REC;
          rec_start_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (bus.i_key_stop || bus.i_dsp_done || (bus.i_dsp_addr >= end_addr_q)) begin
          state_d    = S_IDLE;
          dsp_stop_d = 1'b1;
        end else if (bus.i_key_play) begin
          state_d     = S_PLAY_PAUSE;
          dsp_pause_d = 1'b1;
        end
      end
      S_PLAY_PAUSE: begin
        if (bus.i_key_stop) begin
          state_d    = S_IDLE;
          dsp_stop_d = 1'b1;
        end else if (bus.i_key_play) begin
          state_d     = S_PLAY;
          dsp_start_d = 1'b1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Register state and pulses together so each pulse follows its key by one edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= S_INIT;
      init_pend_q  <= 1'b1;
      init_start_q <= 1'b0;
      rec_start_q  <= 1'b0;
      rec_pause_q  <= 1'b0;
      rec_stop_q   <= 1'b0;
      dsp_start_q  <= 1'b0;
      dsp_pause_q  <= 1'b0;
      dsp_stop_q   <= 1'b0;
      owner_q      <= 1'b0;
      end_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      init_pend_q  <= 1'b0;
      init_start_q <= init_pend_q;
      rec_start_q  <= rec_start_d;
      rec_pause_q  <= rec_pause_d;
      rec_stop_q   <= rec_stop_d;
      dsp_start_q  <= dsp_start_d;
      dsp_pause_q  <= dsp_pause_d;
      dsp_stop_q   <= dsp_stop_d;
      owner_q      <= (state_d == S_PLAY) || (state_d == S_PLAY_PAUSE);
      end_addr_q   <= end_addr_d;
    end
  end

  // Only one timer is enabled at a time, so each keeps its own sub-second phase.
  sec_timer #(.SAMPLES_PER_SEC(SAMPLES_PER_SEC), .TIME_W(TIME_W)) u_rec_timer (
    .clk_sys (i_clk),
    .rst_b   (i_rst_n),
    .en      (state_q == S_REC),
    .clr     (rec_clr),
    .tick    (bus.i_sample_tick),
    .secs    (rec_time)
  );

  sec_timer #(.SAMPLES_PER_SEC(SAMPLES_PER_SEC), .TIME_W(TIME_W)) u_play_timer (
    .clk_sys (i_clk),
    .rst_b   (i_rst_n),
    .en      (state_q == S_PLAY),
    .clr     (play_clr),
    .tick    (bus.i_sample_tick),
    .secs    (play_time)
  );

  assign bus.o_init_start = init_start_q;
  assign bus.o_rec_start  = rec_start_q;
  assign bus.o_rec_pause  = rec_pause_q;
  assign bus.o_rec_stop   = rec_stop_q;
  assign bus.o_dsp_start  = dsp_start_q;
  assign bus.o_dsp_pause  = dsp_pause_q;
  assign bus.o_dsp_stop   = dsp_stop_q;
  assign bus.o_sram_owner = owner_q;
  assign bus.o_end_addr   = end_addr_q;
  assign bus.o_state      = state_q;
  assign bus.o_rec_time   = rec_time;
  assign bus.o_play_time  = play_time;

endmodule

// File: tb/tb_audio_session_ctrl.sv
// Directed, table-driven bench for audio_session_ctrl (4 samples per second).
module tb_audio_session_ctrl;

  localparam int ADDR_W = 20;
  localparam int TIME_W = 6;

  localparam logic [2:0] K_REC  = 3'b100;
  localparam logic [2:0] K_PLAY = 3'b010;
  localparam logic [2:0] K_STOP = 3'b001;

  // pulse vector order: rec_start rec_pause rec_stop dsp_start dsp_pause dsp_stop
  localparam logic [5:0] P_RS = 6'b100000;
  localparam logic [5:0] P_RP = 6'b010000;
  localparam logic [5:0] P_RX = 6'b001000;
  localparam logic [5:0] P_DS = 6'b000100;
  localparam logic [5:0] P_DP = 6'b000010;
  localparam logic [5:0] P_DX = 6'b000001;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  audio_session_ctrl_if #(.ADDR_W(ADDR_W), .TIME_W(TIME_W)) bus ();

  audio_session_ctrl #(
    .ADDR_W          (ADDR_W),
    .MAX_ADDR        (20'hFFFFF),
    .SAMPLES_PER_SEC (4),
    .TIME_W          (TIME_W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  keys;
    logic        tick;
    logic [19:0] ra;
    logic [19:0] da;
    logic        done;
    int          n;
    logic [2:0]  st;
    logic [5:0]  p;
    logic        own;
    logic [19:0] ea;
    logic [5:0]  rt;
    logic [5:0]  pt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] keys, logic tick, logic [19:0] ra, logic [19:0] da,
                              logic done, int n, logic [2:0] st, logic [5:0] p, logic own,
                              logic [19:0] ea, logic [5:0] rt, logic [5:0] pt);
    vec_t v;
    v.keys = keys; v.tick = tick; v.ra = ra; v.da = da; v.done = done; v.n = n;
    v.st = st; v.p = p; v.own = own; v.ea = ea; v.rt = rt; v.pt = pt;
    return v;
  endfunction

  function automatic logic [5:0] pulses();
    return {bus.o_rec_start, bus.o_rec_pause, bus.o_rec_stop,
            bus.o_dsp_start, bus.o_dsp_pause, bus.o_dsp_stop};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.i_key_rec     = 1'b0;
    bus.i_key_play    = 1'b0;
    bus.i_key_stop    = 1'b0;
    bus.i_init_done   = 1'b0;
    bus.i_sample_tick = 1'b0;
    bus.i_rec_addr    = '0;
    bus.i_dsp_addr    = '0;
    bus.i_dsp_done    = 1'b0;

    // vectors start from S_IDLE with no recording present
    vecs.push_back(mk(K_PLAY,          0, 20'h0,     20'h0,   0, 1,   3'd1, 6'd0, 0, 20'h0,     6'd0,  6'd0));
    vecs.push_back(mk(K_REC,           0, 20'h0,     20'h0,   0, 1,   3'd2, P_RS, 0, 20'h0,     6'd0,  6'd0));
    vecs.push_back(mk(3'b000,          1, 20'h0,     20'h0,   0, 9,   3'd2, 6'd0, 0, 20'h0,     6'd2,  6'd0));
    vecs.push_back(mk(K_REC,           0, 20'h0,     20'h0,   0, 1,   3'd3, P_RP, 0, 20'h0,     6'd2,  6'd0));
    vecs.push_back(mk(3'b000,          1, 20'h0,     20'h0,   0, 5,   3'd3, 6'd0, 0, 20'h0,     6'd2,  6'd0));
    vecs.push_back(mk(K_REC,           0, 20'h0,     20'h0,   0, 1,   3'd2, P_RS, 0, 20'h0,     6'd2,  6'd0));
    vecs.push_back(mk(3'b000,          1, 20'h0,     20'h0,   0, 3,   3'd2, 6'd0, 0, 20'h0,     6'd3,  6'd0));
    vecs.push_back(mk(K_PLAY,          0, 20'h0,     20'h0,   0, 1,   3'd2, 6'd0, 0, 20'h0,     6'd3,  6'd0));
    vecs.push_back(mk(K_STOP,          0, 20'h00123, 20'h0,   0, 1,   3'd1, P_RX, 0, 20'h00123, 6'd3,  6'd0));
    vecs.push_back(mk(K_PLAY,          0, 20'h0,     20'h0,   0, 1,   3'd4, P_DS, 1, 20'h00123, 6'd3,  6'd0));
    vecs.push_back(mk(3'b000,          1, 20'h0,     20'h100, 0, 4,   3'd4, 6'd0, 1, 20'h00123, 6'd3,  6'd1));
    vecs.push_back(mk(K_REC,           0, 20'h0,     20'h120, 0, 1,   3'd4, 6'd0, 1, 20'h00123, 6'd3,  6'd1));
    vecs.push_back(mk(3'b000,          0, 20'h0,     20'h123, 0, 1,   3'd1, P_DX, 0, 20'h00123, 6'd3,  6'd1));
    vecs.push_back(mk(K_PLAY,          0, 20'h0,     20'h0,   0, 1,   3'd4, P_DS, 1, 20'h00123, 6'd3,  6'd0));
    vecs.push_back(mk(K_PLAY,          0, 20'h0,     20'h0,   0, 1,   3'd5, P_DP, 1, 20'h00123, 6'd3,  6'd0));
    vecs.push_back(mk(3'b000,          1, 20'h0,     20'h0,   0, 4,   3'd5, 6'd0, 1, 20'h00123, 6'd3,  6'd0));
    vecs.push_back(mk(K_PLAY,          0, 20'h0,     20'h0,   0, 1,   3'd4, P_DS, 1, 20'h00123, 6'd3,  6'd0));
    vecs.push_back(mk(3'b000,          0, 20'h0,     20'h0,   1, 1,   3'd1, P_DX, 0, 20'h00123, 6'd3,  6'd0));
    vecs.push_back(mk(K_REC,           0, 20'h0,     20'h0,   0, 1,   3'd2, P_RS, 0, 20'h00123, 6'd0,  6'd0));
    vecs.push_back(mk(3'b000,          0, 20'hFFFFF, 20'h0,   0, 1,   3'd1, P_RX, 0, 20'hFFFFF, 6'd0,  6'd0));
    vecs.push_back(mk(K_REC | K_STOP,  0, 20'h0,     20'h0,   0, 1,   3'd1, 6'd0, 0, 20'hFFFFF, 6'd0,  6'd0));
    vecs.push_back(mk(K_STOP,          0, 20'h0,     20'h0,   0, 1,   3'd1, 6'd0, 0, 20'hFFFFF, 6'd0,  6'd0));
    vecs.push_back(mk(K_REC,           0, 20'h0,     20'h0,   0, 1,   3'd2, P_RS, 0, 20'hFFFFF, 6'd0,  6'd0));
    vecs.push_back(mk(K_REC | K_PLAY,  0, 20'h0,     20'h0,   0, 1,   3'd3, P_RP, 0, 20'hFFFFF, 6'd0,  6'd0));
    vecs.push_back(mk(K_STOP,          0, 20'h00055, 20'h0,   0, 1,   3'd1, P_RX, 0, 20'h00055, 6'd0,  6'd0));
    vecs.push_back(mk(K_REC,           0, 20'h0,     20'h0,   0, 1,   3'd2, P_RS, 0, 20'h00055, 6'd0,  6'd0));
    vecs.push_back(mk(3'b000,          1, 20'h0,     20'h0,   0, 260, 3'd2, 6'd0, 0, 20'h00055, 6'd63, 6'd0));
    vecs.push_back(mk(K_STOP,          0, 20'h0,     20'h0,   0, 1,   3'd1, P_RX, 0, 20'h0,     6'd63, 6'd0));
    vecs.push_back(mk(K_PLAY,          0, 20'h0,     20'h0,   0, 1,   3'd1, 6'd0, 0, 20'h0,     6'd63, 6'd0));
    vecs.push_back(mk(K_REC,           0, 20'h0,     20'h0,   0, 1,   3'd2, P_RS, 0, 20'h0,     6'd0,  6'd0));
    vecs.push_back(mk(K_STOP,          0, 20'h00200, 20'h0,   0, 1,   3'd1, P_RX, 0, 20'h00200, 6'd0,  6'd0));
    vecs.push_back(mk(K_PLAY,          0, 20'h0,     20'h0,   0, 1,   3'd4, P_DS, 1, 20'h00200, 6'd0,  6'd0));
    vecs.push_back(mk(3'b000,          1, 20'h0,     20'h010, 0, 5,   3'd4, 6'd0, 1, 20'h00200, 6'd0,  6'd1));

    // reset and codec init
    repeat (3) cyc();
    chk("rst_state",      0, bus.o_state,      3'd0);
    chk("rst_init_start", 0, bus.o_init_start, 1'b0);
    chk("rst_pulses",     0, pulses(),         6'd0);
    chk("rst_owner",      0, bus.o_sram_owner, 1'b0);
    chk("rst_end_addr",   0, bus.o_end_addr,   20'h0);
    chk("rst_times",      0, {bus.o_rec_time, bus.o_play_time}, 12'd0);

    rst_n = 1'b1;
    cyc();
    chk("init_start_hi", 1, bus.o_init_start, 1'b1);
    chk("init_state",    1, bus.o_state,      3'd0);
    bus.i_key_rec = 1'b1;
    cyc();
    bus.i_key_rec = 1'b0;
    chk("init_start_lo", 2, bus.o_init_start, 1'b0);
    chk("init_rec_key",  2, pulses(),         6'd0);
    chk("init_state",    2, bus.o_state,      3'd0);
    repeat (8) cyc();
    chk("init_wait",     3, bus.o_state,      3'd0);
    chk("init_once",     3, bus.o_init_start, 1'b0);
    bus.i_init_done = 1'b1;
    cyc();
    chk("init_done_st",  4, bus.o_state,      3'd1);
    chk("init_done_p",   4, pulses(),         6'd0);
    chk("init_done_is",  4, bus.o_init_start, 1'b0);

    foreach (vecs[i]) begin
      bus.i_key_rec     = vecs[i].keys[2];
      bus.i_key_play    = vecs[i].keys[1];
      bus.i_key_stop    = vecs[i].keys[0];
      bus.i_sample_tick = vecs[i].tick;
      bus.i_rec_addr    = vecs[i].ra;
      bus.i_dsp_addr    = vecs[i].da;
      bus.i_dsp_done    = vecs[i].done;
      for (int c = 0; c < vecs[i].n; c++) begin
        cyc();
        bus.i_key_rec  = 1'b0;
        bus.i_key_play = 1'b0;
        bus.i_key_stop = 1'b0;
      end
      bus.i_sample_tick = 1'b0;
      bus.i_dsp_done    = 1'b0;
      bus.i_rec_addr    = '0;
      chk("state",     i, bus.o_state,      vecs[i].st);
      chk("pulses",    i, pulses(),         vecs[i].p);
      chk("owner",     i, bus.o_sram_owner, vecs[i].own);
      chk("end_addr",  i, bus.o_end_addr,   vecs[i].ea);
      chk("rec_time",  i, bus.o_rec_time,   vecs[i].rt);
      chk("play_time", i, bus.o_play_time,  vecs[i].pt);
    end

    // reset in the middle of playback aborts without a stop pulse
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_state", 100, bus.o_state,      3'd0);
    chk("mid_rst_pulse", 100, pulses(),         6'd0);
    chk("mid_rst_owner", 100, bus.o_sram_owner, 1'b0);
    chk("mid_rst_end",   100, bus.o_end_addr,   20'h0);
    chk("mid_rst_pt",    100, bus.o_play_time,  6'd0);
    rst_n = 1'b1;
    cyc();
    chk("re_init_start", 101, bus.o_init_start, 1'b1);
    chk("re_init_state", 101, bus.o_state,      3'd1);
    cyc();
    chk("re_init_once",  102, bus.o_init_start, 1'b0);
    chk("re_init_pulse", 102, pulses(),         6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
